// File: rtl/wdt_kick_master.sv
// -----------------------------------------------------------------------------
// wdt_kick_master
//
// Avalon-MM master that services the on-chip watchdog timer slave. It starts
// the watchdog, polls its status and then kicks it periodically (write to the
// period-low register) for as long as the system heartbeat keeps arriving. If
// the heartbeat is lost the block stops kicking on purpose, so the watchdog
// reset request fires.
//
// Ports:
//   clk            clock
//   reset_n        asynchronous reset, active-low
//   enable         level; start / keep servicing the watchdog
//   alive          single-cycle heartbeat pulse from the system
//   av_address     slave register address
//   av_chipselect  slave select
//   av_write_n     active-low write strobe
//   av_writedata   write data
//   av_readdata    slave readdata (registered in the slave, 1-cycle latency)
//   kick_count     number of kicks issued, wraps 0xFFFF -> 0
//   wdt_running    last polled status bit1
//   wdt_fired      sticky, set when a poll sees status bit0 = 1
//   fired_clr      pulse, clears wdt_fired (a same-cycle set wins)
//   starving       sticky, kicking stopped because the heartbeat was lost
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module wdt_kick_master #(
    parameter int unsigned KICK_INTERVAL  = 1000000,
    parameter int unsigned HEALTH_TIMEOUT = 2500000,
    parameter bit          IRQ_EN         = 1'b0,
    parameter int unsigned CW             = 23
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        alive,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    output logic [15:0] kick_count,
    output logic        wdt_running,
    output logic        wdt_fired,
    input  logic        fired_clr,
    output logic        starving
);

    // Watchdog slave register map.
    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERIODL = 3'd2;

    // Control word: start (bit2) plus optional interrupt enable (bit0).
    localparam logic [15:0] CTRL_START   = 16'h0004 | {15'd0, IRQ_EN};

    localparam logic [CW-1:0] INTERVAL_LOAD = CW'(KICK_INTERVAL - 1);
    localparam logic [CW-1:0] HEALTH_MAX    = CW'(HEALTH_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_POLL_A,
        S_POLL_B,
        S_CLR,
        S_WAIT,
        S_KICK,
        S_STARVE
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0] interval_q, interval_d;
    logic [CW-1:0] health_q, health_d;
    logic [15:0]   kick_count_q, kick_count_d;
    logic          wdt_running_q, wdt_running_d;
    logic          wdt_fired_q, wdt_fired_d;
    logic          starving_q, starving_d;

    logic [2:0]    av_address_q, av_address_d;
    logic          av_chipselect_q, av_chipselect_d;
    logic          av_write_n_q, av_write_n_d;
    logic [15:0]   av_writedata_q, av_writedata_d;

    logic          health_fail;
    logic          status_timeout;
    logic          status_running;
    logic          unused_readdata;

    assign status_timeout  = av_readdata[0];
    assign status_running  = av_readdata[1];
    assign unused_readdata = ^av_readdata[15:2];

    // Evaluated on the registered count, so an alive pulse arriving in the
    // cycle the count would reach the limit clears it before it can fail.
    assign health_fail = (health_q == HEALTH_MAX);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_INIT;
                end
            end
            S_INIT:   state_d = S_POLL_A;
            S_POLL_A: state_d = S_POLL_B;
            S_POLL_B: begin
                if (status_timeout) begin
                    state_d = S_CLR;
                end else if (!status_running) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CLR:    state_d = S_WAIT;
            S_WAIT: begin
                // Heartbeat loss outranks disable, which outranks the kick.
                if (health_fail) begin
                    state_d = S_STARVE;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else if (interval_q == '0) begin
                    state_d = S_KICK;
                end
            end
            S_KICK:   state_d = S_POLL_A;
            S_STARVE: state_d = S_STARVE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: bus outputs, decoded from the next state and registered so the
    // bus reflects the current state with no input-to-output path.
    // -------------------------------------------------------------------------
    always_comb begin
        av_chipselect_d = 1'b0;
        av_write_n_d    = 1'b1;
        av_address_d    = ADDR_STATUS;
        av_writedata_d  = '0;
        case (state_d)
            S_INIT: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = ADDR_CONTROL;
                av_writedata_d  = CTRL_START;
            end
            S_POLL_A: begin
                av_chipselect_d = 1'b1;
            end
            S_CLR: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = ADDR_STATUS;
            end
            S_KICK: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = ADDR_PERIODL;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters and status flags
    // -------------------------------------------------------------------------
    always_comb begin
        interval_d = interval_q;
        if ((state_d == S_WAIT) && (state_q != S_WAIT)) begin
            interval_d = INTERVAL_LOAD;
        end else if ((state_q == S_WAIT) && (interval_q != '0)) begin
            interval_d = interval_q - CW'(1);
        end
    end

    always_comb begin
        health_d = health_q;
        if (state_q == S_IDLE) begin
            health_d = '0;
        end else if (state_q != S_STARVE) begin
            if (alive) begin
                health_d = '0;
            end else if (health_q != HEALTH_MAX) begin
                health_d = health_q + CW'(1);
            end
        end
    end

    always_comb begin
        kick_count_d  = kick_count_q;
        wdt_running_d = wdt_running_q;
        wdt_fired_d   = wdt_fired_q;
        starving_d    = starving_q;

        if (state_q == S_KICK) begin
            kick_count_d = kick_count_q + 16'd1;
        end

        if (state_q == S_POLL_B) begin
            wdt_running_d = status_running;
        end

        if ((state_q == S_POLL_B) && status_timeout) begin
            wdt_fired_d = 1'b1;
        end else if (fired_clr) begin
            wdt_fired_d = 1'b0;
        end

        if (state_d == S_STARVE) begin
            starving_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interval_q      <= '0;
            health_q        <= '0;
            kick_count_q    <= '0;
            wdt_running_q   <= 1'b0;
            wdt_fired_q     <= 1'b0;
            starving_q      <= 1'b0;
            av_address_q    <= '0;
            av_chipselect_q <= 1'b0;
            av_write_n_q    <= 1'b1;
            av_writedata_q  <= '0;
        end else begin
            interval_q      <= interval_d;
            health_q        <= health_d;
            kick_count_q    <= kick_count_d;
            wdt_running_q   <= wdt_running_d;
            wdt_fired_q     <= wdt_fired_d;
            starving_q      <= starving_d;
            av_address_q    <= av_address_d;
            av_chipselect_q <= av_chipselect_d;
            av_write_n_q    <= av_write_n_d;
            av_writedata_q  <= av_writedata_d;
        end
    end

    assign av_address    = av_address_q;
    assign av_chipselect = av_chipselect_q;
    assign av_write_n    = av_write_n_q;
    assign av_writedata  = av_writedata_q;
    assign kick_count    = kick_count_q;
    assign wdt_running   = wdt_running_q;
    assign wdt_fired     = wdt_fired_q;
    assign starving      = starving_q;

endmodule

// File: tb/tb_wdt_kick_master.sv
// -----------------------------------------------------------------------------
// tb_wdt_kick_master
//
// Drives wdt_kick_master against a small watchdog slave model whose status
// replies come from a script queue. A transaction-level model predicts every
// output each cycle; directed scenarios add literal timing expectations.
// -----------------------------------------------------------------------------
module tb_wdt_kick_master;

    localparam int unsigned KI = 8;
    localparam int unsigned HT = 40;
    localparam bit          IE = 1'b1;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic        alive     = 1'b0;
    logic        fired_clr = 1'b0;
    logic [15:0] av_readdata = '0;

    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] kick_count;
    logic        wdt_running;
    logic        wdt_fired;
    logic        starving;

    wdt_kick_master #(
        .KICK_INTERVAL (KI),
        .HEALTH_TIMEOUT(HT),
        .IRQ_EN        (IE),
        .CW            (23)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .alive        (alive),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write_n   (av_write_n),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .kick_count   (kick_count),
        .wdt_running  (wdt_running),
        .wdt_fired    (wdt_fired),
        .fired_clr    (fired_clr),
        .starving     (starving)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- watchdog slave model ----------------
    logic [15:0] status_default = 16'h0002;
    logic [15:0] script[$];

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                av_readdata <= '0;
            end else if (av_chipselect && av_write_n) begin
                if (script.size() > 0) av_readdata <= script.pop_front();
                else                   av_readdata <= status_default;
            end
        end
    end

    // ---------------- heartbeat generator ----------------
    int alive_period = 0;
    int acnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (alive_period > 0 && acnt >= alive_period - 1) begin
                alive = 1'b1;
                acnt  = 0;
            end else begin
                alive = 1'b0;
                if (alive_period > 0) acnt++;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    // Activity of the current cycle: idle, a scheduled bus beat, waiting
    // between kicks, or starved. Bus beats are queued one service at a time.
    typedef struct packed {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        poll;
        logic        kick;
    } beat_t;

    typedef enum {M_IDLE, M_BEAT, M_WAIT, M_STARVE} act_e;

    act_e        m_act = M_IDLE;
    beat_t       m_cur = '0;
    beat_t       m_q[$];
    int          m_wait = 0;
    int          m_health = 0;
    logic [15:0] m_kicks = '0;
    logic        m_running = 1'b0;
    logic        m_fired = 1'b0;
    logic        m_starving = 1'b0;

    function automatic beat_t mk(input logic cs, input logic wn, input logic [2:0] a,
                                 input logic [15:0] d, input logic poll, input logic kick);
        beat_t b;
        b.cs = cs; b.wn = wn; b.addr = a; b.data = d; b.poll = poll; b.kick = kick;
        return b;
    endfunction

    // One service = a write, then the two-cycle status read.
    task automatic push_service(input logic [2:0] a, input logic [15:0] d, input logic k);
        m_q.push_back(mk(1'b1, 1'b0, a, d, 1'b0, k));
        m_q.push_back(mk(1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0));
        m_q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0));
    endtask

    task automatic model_step();
        bit fail;
        if (!reset_n) begin
            m_act = M_IDLE; m_q.delete(); m_wait = 0; m_health = 0;
            m_kicks = '0; m_running = 1'b0; m_fired = 1'b0; m_starving = 1'b0;
            return;
        end
        fail = (m_health == HT);
        if (m_act == M_IDLE) m_health = 0;
        else if (m_act != M_STARVE) begin
            if (alive) m_health = 0;
            else if (m_health < HT) m_health++;
        end
        if (fired_clr) m_fired = 1'b0;
        case (m_act)
            M_IDLE: begin
                if (enable) begin
                    push_service(3'd1, 16'h0004 | {15'd0, IE}, 1'b0);
                    m_cur = m_q.pop_front();
                    m_act = M_BEAT;
                end
            end
            M_BEAT: begin
                if (m_cur.kick) m_kicks = m_kicks + 16'd1;
                if (m_cur.poll) begin
                    m_running = av_readdata[1];
                    if (av_readdata[0]) begin
                        m_fired = 1'b1;
                        m_q.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
                    end else if (!av_readdata[1]) begin
                        push_service(3'd1, 16'h0004 | {15'd0, IE}, 1'b0);
                    end
                end
                if (m_q.size() > 0) m_cur = m_q.pop_front();
                else begin
                    m_act  = M_WAIT;
                    m_wait = KI;
                end
            end
            M_WAIT: begin
                if (fail) begin
                    m_act = M_STARVE;
                    m_starving = 1'b1;
                end else if (!enable) begin
                    m_act = M_IDLE;
                end else if (m_wait <= 1) begin
                    push_service(3'd2, 16'h0000, 1'b1);
                    m_cur = m_q.pop_front();
                    m_act = M_BEAT;
                end else begin
                    m_wait--;
                end
            end
            default: begin
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int addr0_writes = 0;

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            e = (m_act == M_BEAT) ? m_cur : mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0);
            check("av_chipselect", av_chipselect, e.cs);
            check("av_write_n",    av_write_n,    e.wn);
            check("av_address",    av_address,    e.addr);
            check("av_writedata",  av_writedata,  e.data);
            check("kick_count",    kick_count,    m_kicks);
            check("wdt_running",   wdt_running,   m_running);
            check("wdt_fired",     wdt_fired,     m_fired);
            check("starving",      starving,      m_starving);
            if (av_chipselect && !av_write_n && av_address == 3'd0) addr0_writes++;
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_write(input logic [2:0] a, input int budget, input string name, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (av_chipselect && !av_write_n && av_address == a) begin
                when = cyc;
                break;
            end
        end
        check({name, " seen"}, 32'(when >= 0), 1);
    endtask

    task automatic wait_read(input int budget, input string name);
        int found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (av_chipselect && av_write_n) begin
                found = 1;
                break;
            end
        end
        check({name, " seen"}, found, 1);
    endtask

    initial begin
        int t, t_prev, k_exp, busy, cnt0, found;
        logic [15:0] k_frozen;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset kick_count", kick_count, 0);
        check("reset chipselect", av_chipselect, 0);
        check("reset write_n", av_write_n, 1);
        check("reset address", av_address, 0);
        check("reset starving", starving, 0);
        check("reset fired", wdt_fired, 0);
        check("reset running", wdt_running, 0);

        // Start-up with a not-running first reply: INIT repeats.
        script.push_back(16'h0000);
        @(posedge clk);
        #1 enable = 1'b1;
        alive_period = 20;
        wait_write(3'd1, 5, "init write", t);
        check("init data", av_writedata, 16'h0005);
        t_prev = t;
        wait_write(3'd1, 8, "re-init write", t);
        check("re-init spacing", t - t_prev, 3);
        t_prev = t;
        wait_write(3'd2, 20, "first kick", t);
        check("init-to-kick", t - t_prev, 11);
        check("running after poll", wdt_running, 1);
        check("count at first kick", kick_count, 0);

        // Steady state: kicks every KI+3 cycles.
        k_exp = 0;
        t_prev = t;
        cnt0 = addr0_writes;
        repeat (18) begin
            wait_write(3'd2, 20, "kick", t);
            k_exp++;
            check("kick spacing", t - t_prev, 11);
            check("kick count step", kick_count, k_exp);
            t_prev = t;
        end
        check("no status writes", addr0_writes - cnt0, 0);
        check("steady starving", starving, 0);

        // Heartbeat exactly HT apart: alive always wins against the limit.
        alive_period = 40;
        repeat (300) @(negedge clk);
        check("alive at limit starving", starving, 0);
        wait_write(3'd2, 15, "kick with 40-spaced alive", t);

        // Timeout seen once: clear write, then WAIT.
        script.push_back(16'h0003);
        wait_write(3'd0, 20, "status clear write", t);
        check("clear data", av_writedata, 16'h0000);
        check("fired set", wdt_fired, 1);
        t_prev = t;
        @(posedge clk);
        #1 fired_clr = 1'b1;
        @(posedge clk);
        #1 fired_clr = 1'b0;
        @(negedge clk);
        check("fired cleared", wdt_fired, 0);
        wait_write(3'd2, 15, "kick after clear", t);
        check("clear-to-kick", t - t_prev, 9);

        // Second timeout poll with a coincident fired_clr: set wins.
        script.push_back(16'h0003);
        wait_read(3, "poll after kick");
        @(posedge clk);
        #1 fired_clr = 1'b1;
        @(posedge clk);
        #1 fired_clr = 1'b0;
        @(negedge clk);
        check("fired set beats clear", wdt_fired, 1);
        check("second clear write", av_chipselect && !av_write_n && av_address == 3'd0, 1);

        // Disable during KICK: poll completes, then the bus goes quiet.
        wait_write(3'd2, 20, "kick before disable", t);
        enable = 1'b0;
        @(negedge clk);
        check("poll after disable", av_chipselect && av_write_n, 1);
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (av_chipselect) busy++;
        end
        check("bus idle after disable", busy, 0);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_write(3'd1, 5, "init after re-enable", t);

        // Heartbeat loss: starve, bus silent, count frozen, fired_clr harmless.
        wait_write(3'd2, 20, "kick before heartbeat loss", t);
        alive_period = 0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (starving) begin
                found = 1;
                break;
            end
        end
        check("starving set", found, 1);
        k_frozen = kick_count;
        busy = 0;
        @(posedge clk);
        #1 fired_clr = 1'b1;
        @(posedge clk);
        #1 fired_clr = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (av_chipselect) busy++;
        end
        check("bus idle while starving", busy, 0);
        check("kick_count frozen", kick_count, k_frozen);
        check("starving sticky", starving, 1);

        // Reset recovers and INIT is reissued.
        @(posedge clk);
        #1 reset_n = 1'b0;
        alive_period = 20;
        @(negedge clk);
        check("reset2 kick_count", kick_count, 0);
        check("reset2 starving", starving, 0);
        check("reset2 fired", wdt_fired, 0);
        check("reset2 running", wdt_running, 0);
        check("reset2 chipselect", av_chipselect, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_write(3'd1, 5, "init after reset", t);
        check("init data after reset", av_writedata, 16'h0005);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
